// File: rtl/time_display_driver.sv
// rtl/time_display_driver.sv - HH:MM:SS seven-segment driver with sequential BCD conversion and alarm blink
module time_display_driver #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [15:0] hours_in,
  input  logic [15:0] minutes_in,
  input  logic [15:0] seconds_in,
  input  logic        alarm_in,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        frame_done
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_SHIFT,
    S_STORE,
    S_COMMIT
  } state_t;

  state_t      state_q;
  logic [1:0]  field_q;       // 0 = hours, 1 = minutes, 2 = seconds
  logic [2:0]  shift_cnt_q;
  logic [6:0]  bin_q;
  logic [7:0]  bcd_q;
  logic [15:0] cap_h_q;
  logic [15:0] cap_m_q;
  logic [15:0] cap_s_q;
  logic [3:0]  h_tens_q, h_units_q;
  logic [3:0]  m_tens_q, m_units_q;
  logic [3:0]  s_tens_q, s_units_q;
  logic        h_dash_q, m_dash_q, s_dash_q;
  logic [6:0]  seg_q [6];
  logic        frame_done_q;

  logic [CNT_W-1:0] blink_cnt_q;
  logic             blank_q;

  logic [2:0]  adj_t;
  logic [3:0]  adj_u;
  logic [7:0]  bcd_d;
  logic [6:0]  bin_d;
  logic [15:0] field_val;
  logic [6:0]  next_bin;
  logic        field_over;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // One double-dabble step: add-3 on nibbles >=5, then shift the next binary bit in.
  // The tens correction is kept to 3 bits; a carry out only happens for values that show dashes.
  always_comb begin
    adj_t = (bcd_q[7:4] >= 4'd5) ? (bcd_q[6:4] + 3'd3) : bcd_q[6:4];
    adj_u = (bcd_q[3:0] >= 4'd5) ? (bcd_q[3:0] + 4'd3) : bcd_q[3:0];
    bcd_d = {adj_t, adj_u, bin_q[6]};
    bin_d = {bin_q[5:0], 1'b0};
  end

  // Select the captured field being stored and the binary bits of the field that follows it.
  always_comb begin
    field_val = cap_h_q;
    next_bin  = cap_m_q[6:0];
    case (field_q)
      2'd0: begin
        field_val = cap_h_q;
        next_bin  = cap_m_q[6:0];
      end
      2'd1: begin
        field_val = cap_m_q;
        next_bin  = cap_s_q[6:0];
      end
      default: begin
        field_val = cap_s_q;
        next_bin  = cap_s_q[6:0];
      end
    endcase
    field_over = (field_val > 16'd99);
  end

  // Frame sequencer: capture, convert H/M/S in turn, then commit all six digits at once.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= S_CAPTURE;
      field_q      <= 2'd0;
      shift_cnt_q  <= 3'd0;
      bin_q        <= 7'd0;
      bcd_q        <= 8'd0;
      cap_h_q      <= 16'd0;
      cap_m_q      <= 16'd0;
      cap_s_q      <= 16'd0;
      h_tens_q     <= 4'd0;
      h_units_q    <= 4'd0;
      m_tens_q     <= 4'd0;
      m_units_q    <= 4'd0;
      s_tens_q     <= 4'd0;
      s_units_q    <= 4'd0;
      h_dash_q     <= 1'b0;
      m_dash_q     <= 1'b0;
      s_dash_q     <= 1'b0;
      for (int i = 0; i < 6; i++) seg_q[i] <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_CAPTURE: begin
          cap_h_q     <= hours_in;
          cap_m_q     <= minutes_in;
          cap_s_q     <= seconds_in;
          bin_q       <= hours_in[6:0];
          bcd_q       <= 8'd0;
          field_q     <= 2'd0;
          shift_cnt_q <= 3'd0;
          state_q     <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          if (shift_cnt_q == 3'd6) begin
            shift_cnt_q <= 3'd0;
            state_q     <= S_STORE;
          end else begin
            shift_cnt_q <= shift_cnt_q + 3'd1;
          end
        end
        S_STORE: begin
          case (field_q)
            2'd0: begin
              h_tens_q  <= bcd_q[7:4];
              h_units_q <= bcd_q[3:0];
              h_dash_q  <= field_over;
            end
            2'd1: begin
              m_tens_q  <= bcd_q[7:4];
              m_units_q <= bcd_q[3:0];
              m_dash_q  <= field_over;
            end
            default: begin
              s_tens_q  <= bcd_q[7:4];
              s_units_q <= bcd_q[3:0];
              s_dash_q  <= field_over;
            end
          endcase
          if (field_q == 2'd2) begin
            state_q <= S_COMMIT;
          end else begin
            field_q <= field_q + 2'd1;
            bin_q   <= next_bin;
            bcd_q   <= 8'd0;
            state_q <= S_SHIFT;
          end
        end
        S_COMMIT: begin
          seg_q[5]     <= h_dash_q ? SEG_DASH : seg_code(h_tens_q);
          seg_q[4]     <= h_dash_q ? SEG_DASH : seg_code(h_units_q);
          seg_q[3]     <= m_dash_q ? SEG_DASH : seg_code(m_tens_q);
          seg_q[2]     <= m_dash_q ? SEG_DASH : seg_code(m_units_q);
          seg_q[1]     <= s_dash_q ? SEG_DASH : seg_code(s_tens_q);
          seg_q[0]     <= s_dash_q ? SEG_DASH : seg_code(s_units_q);
          frame_done_q <= 1'b1;
          state_q      <= S_CAPTURE;
        end
        default: state_q <= S_CAPTURE;
      endcase
    end
  end

  // Blink timebase: free-runs only while the alarm is active, so blinking starts visible.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !alarm_in) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_q <= '0;
      blank_q     <= ~blank_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign hex5       = blank_q ? SEG_BLANK : seg_q[5];
  assign hex4       = blank_q ? SEG_BLANK : seg_q[4];
  assign hex3       = blank_q ? SEG_BLANK : seg_q[3];
  assign hex2       = blank_q ? SEG_BLANK : seg_q[2];
  assign hex1       = blank_q ? SEG_BLANK : seg_q[1];
  assign hex0       = blank_q ? SEG_BLANK : seg_q[0];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_time_display_driver.sv
// tb/tb_time_display_driver.sv - randomized self-checking bench for time_display_driver
module tb_time_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] h_in, m_in, s_in;
  logic        alarm;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
  logic        fd;

  int passed = 0;
  int total  = 0;

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  time_display_driver #(.BLINK_DIV(4)) dut (
    .clk_clk     (clk),
    .reset_reset (reset),
    .hours_in    (h_in),
    .minutes_in  (m_in),
    .seconds_in  (s_in),
    .alarm_in    (alarm),
    .hex5        (hex5),
    .hex4        (hex4),
    .hex3        (hex3),
    .hex2        (hex2),
    .hex1        (hex1),
    .hex0        (hex0),
    .frame_done  (fd)
  );

  wire [41:0] shown = {hex5, hex4, hex3, hex2, hex1, hex0};

  // Reference: decimal tens/units lookup, dashes for anything above 99.
  function automatic logic [13:0] pair(input logic [15:0] v);
    int n;
    n = int'(v);
    if (n > 99) return {7'h3F, 7'h3F};
    return {seg_tab[n / 10], seg_tab[n % 10]};
  endfunction

  function automatic logic [41:0] disp(input logic [15:0] h, input logic [15:0] m, input logic [15:0] s);
    return {pair(h), pair(m), pair(s)};
  endfunction

  task automatic wait_fd(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd !== 1'b1 && n < limit);
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    alarm = 1'b0;
    h_in = 16'd12; m_in = 16'd34; s_in = 16'd56;
    repeat (3) @(negedge clk);
    total++;
    if (shown !== ALL_BLANK) $display("FAIL reset_hex: got %h expected %h", shown, ALL_BLANK);
    else passed++;
    total++;
    if (fd !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", fd);
    else passed++;
    reset = 1'b0;
    bad = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (fd !== 1'b0 || shown !== ALL_BLANK) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL first_frame_early: got %0d bad cycles expected 0", bad);
    else passed++;
    @(negedge clk);
    total++;
    if (fd !== 1'b1) $display("FAIL first_frame_done: got %b expected 1 at cycle 26", fd);
    else passed++;
    total++;
    if (shown !== disp(12, 34, 56)) $display("FAIL first_frame_hex: got %h expected %h", shown, disp(12, 34, 56));
    else passed++;
  endtask

  task automatic test_coherence();
    int n;
    h_in = 16'd23; m_in = 16'd59; s_in = 16'd59;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (fd !== 1'b0) $display("FAIL frame_done_width: got %b expected 0", fd);
        else passed++;
      end
      if (k == 10) begin
        h_in = 16'd0; m_in = 16'd0; s_in = 16'd0;
      end
    end
    total++;
    if (fd !== 1'b1) $display("FAIL coherent_period: got %b expected 1", fd);
    else passed++;
    total++;
    if (shown !== disp(23, 59, 59)) $display("FAIL coherent_hex: got %h expected %h", shown, disp(23, 59, 59));
    else passed++;
    wait_fd(40, n);
    total++;
    if (n != 26) $display("FAIL coherent_next_period: got %0d expected 26", n);
    else passed++;
    total++;
    if (shown !== disp(0, 0, 0)) $display("FAIL coherent_next_hex: got %h expected %h", shown, disp(0, 0, 0));
    else passed++;
  endtask

  task automatic test_range();
    logic [15:0] tab_h [4] = '{16'd99, 16'd99, 16'h0080, 16'd0};
    logic [15:0] tab_m [4] = '{16'd100, 16'h0105, 16'h0163, 16'd99};
    logic [15:0] tab_s [4] = '{16'd7, 16'd42, 16'd100, 16'hFFFF};
    int n;
    for (int i = 0; i < 4; i++) begin
      h_in = tab_h[i]; m_in = tab_m[i]; s_in = tab_s[i];
      wait_fd(40, n);
      total++;
      if (n != 26) $display("FAIL range_period_%0d: got %0d expected 26", i, n);
      else passed++;
      total++;
      if (shown !== disp(tab_h[i], tab_m[i], tab_s[i]))
        $display("FAIL range_hex_%0d: got %h expected %h", i, shown, disp(tab_h[i], tab_m[i], tab_s[i]));
      else passed++;
    end
  endtask

  task automatic test_random_frames();
    int n;
    logic [15:0] base;
    base = 16'($urandom_range(0, 95));
    for (int i = 0; i < 10; i++) begin
      h_in = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 99));
      m_in = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 99));
      s_in = base + 16'(i);
      wait_fd(40, n);
      total++;
      if (n != 26) $display("FAIL rand_period_%0d: got %0d expected 26", i, n);
      else passed++;
      total++;
      if (shown !== disp(h_in, m_in, s_in))
        $display("FAIL rand_hex_%0d: got %h expected %h", i, shown, disp(h_in, m_in, s_in));
      else passed++;
    end
  endtask

  task automatic test_blink();
    logic [41:0] vis;
    logic [41:0] exp;
    vis = disp(h_in, m_in, s_in);
    alarm = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp = (((k / 4) % 2) == 1) ? ALL_BLANK : vis;
      total++;
      if (shown !== exp) $display("FAIL blink_cycle_%0d: got %h expected %h", k, shown, exp);
      else passed++;
    end
    alarm = 1'b0;
    @(negedge clk);
    total++;
    if (shown !== vis) $display("FAIL blink_release: got %h expected %h", shown, vis);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (shown !== vis) $display("FAIL blink_idle: got %h expected %h", shown, vis);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int early;
    h_in = 16'd7; m_in = 16'd8; s_in = 16'd9;
    wait_fd(60, n);
    wait_fd(40, n);
    total++;
    if (shown !== disp(7, 8, 9)) $display("FAIL midreset_setup: got %h expected %h", shown, disp(7, 8, 9));
    else passed++;
    early = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (fd !== 1'b0) early++;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (shown !== ALL_BLANK) $display("FAIL midreset_blank: got %h expected %h", shown, ALL_BLANK);
    else passed++;
    total++;
    if (fd !== 1'b0 || early != 0) $display("FAIL midreset_no_done: got fd=%b early=%0d expected 0", fd, early);
    else passed++;
    reset = 1'b0;
    wait_fd(40, n);
    total++;
    if (n != 26) $display("FAIL midreset_period: got %0d expected 26", n);
    else passed++;
    total++;
    if (shown !== disp(7, 8, 9)) $display("FAIL midreset_hex: got %h expected %h", shown, disp(7, 8, 9));
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    alarm = 1'b0;
    h_in = '0; m_in = '0; s_in = '0;
    test_reset();
    test_coherence();
    test_range();
    test_random_frames();
    test_blink();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
